// File: rtl/uart_dbg_responder.sv
// UART debug target: decodes Read/Write/Exec frames from the RX byte stream
// and runs them as 32-bit OBI accesses, replying through the TX byte stream.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o  host->block byte stream
//   tx_data_o/tx_valid_o/tx_ready_i  block->host byte stream
//   obi_req_o/obi_gnt_i, obi_addr_o/obi_we_o/obi_be_o/obi_wdata_o  OBI request
//   obi_rvalid_i/obi_rdata_i/obi_err_i                               OBI response
//   busy_o                           high whenever not in IDLE
module uart_dbg_responder #(
  parameter logic [31:0] BootAddrAddr  = 32'h0300_0000,
  parameter logic [31:0] FetchEnAddr   = 32'h0300_0004,
  parameter int unsigned TimeoutCycles = 20000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o
);
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TimeoutCycles - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WCOLLECT, REQ, RESP,
    RDTX, EXEC_BOOT, EXEC_FETCH, STATUS
  } state_e;

  typedef enum logic [1:0] {
    CMD_RD, CMD_WR, CMD_EX
  } cmd_e;

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [29:0]   words_q, words_d;
  logic [31:0]   buf_q, buf_d;
  logic          err_q, err_d;
  logic          fetch_q, fetch_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   oaddr_q, oaddr_d;
  logic [31:0]   owdata_q, owdata_d;
  logic          owe_q, owe_d;

  logic        collecting;
  logic        rx_fire;
  logic        tx_fire;
  logic        tmo_hit;
  logic [31:0] asm_word;

  assign collecting = state_q inside {ADDR, LEN, WCOLLECT};
  assign rx_ready_o = collecting || (state_q == IDLE);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_valid_o = state_q inside {RDTX, STATUS};
  assign tx_fire    = tx_valid_o && tx_ready_i;
  assign tmo_hit    = !rx_fire && (tmo_q == TmoLast);
  // bytes arrive LSB first, so shift each new byte in at the top
  assign asm_word   = {rx_data_i, buf_q[31:8]};

  assign obi_req_o   = state_q inside {REQ, EXEC_BOOT, EXEC_FETCH};
  assign obi_be_o    = obi_req_o ? 4'hF : 4'h0;
  assign obi_addr_o  = oaddr_q;
  assign obi_we_o    = owe_q;
  assign obi_wdata_o = owdata_q;
  assign busy_o      = state_q != IDLE;

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == RDTX) begin
      tx_data_o = buf_q[7:0];
    end else if (state_q == STATUS) begin
      tx_data_o = err_q ? 8'h04 : 8'h06;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    words_d  = words_q;
    buf_d    = buf_q;
    err_d    = err_q;
    fetch_d  = fetch_q;
    oaddr_d  = oaddr_q;
    owdata_d = owdata_q;
    owe_d    = owe_q;
    tmo_d    = '0;
    if (collecting && !rx_fire) begin
      tmo_d = tmo_q + TW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d = '0;
          unique case (rx_data_i)
            8'h11: begin
              cmd_d   = CMD_RD;
              err_d   = 1'b0;
              state_d = ADDR;
            end
            8'h12: begin
              cmd_d   = CMD_WR;
              err_d   = 1'b0;
              state_d = ADDR;
            end
            8'h13: begin
              cmd_d   = CMD_EX;
              err_d   = 1'b0;
              state_d = ADDR;
            end
            default: begin
              err_d   = 1'b1;
              state_d = STATUS;
            end
          endcase
        end
      end
      ADDR: begin
        if (rx_fire) begin
          buf_d = asm_word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            addr_d = {asm_word[31:2], 2'b00};
            if (cmd_q == CMD_EX) begin
              oaddr_d  = BootAddrAddr;
              owdata_d = {asm_word[31:2], 2'b00};
              owe_d    = 1'b1;
              fetch_d  = 1'b0;
              state_d  = EXEC_BOOT;
            end else begin
              state_d = LEN;
            end
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      LEN: begin
        if (rx_fire) begin
          buf_d = asm_word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            words_d = asm_word[31:2];
            if (asm_word[31:2] == '0) begin
              state_d = STATUS;
            end else if (cmd_q == CMD_RD) begin
              oaddr_d  = addr_q;
              owdata_d = '0;
              owe_d    = 1'b0;
              state_d  = REQ;
            end else begin
              state_d = WCOLLECT;
            end
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      WCOLLECT: begin
        if (rx_fire) begin
          buf_d = asm_word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            oaddr_d  = addr_q;
            owdata_d = asm_word;
            owe_d    = 1'b1;
            state_d  = REQ;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      REQ, EXEC_BOOT, EXEC_FETCH: begin
        if (obi_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (obi_rvalid_i) begin
          err_d  = err_q | obi_err_i;
          addr_d = addr_q + 32'd4;
          cnt_d  = '0;
          unique case (cmd_q)
            CMD_RD: begin
              words_d = words_q - 30'd1;
              buf_d   = obi_rdata_i;
              state_d = RDTX;
            end
            CMD_WR: begin
              words_d = words_q - 30'd1;
              state_d = (words_q == 30'd1) ? STATUS : WCOLLECT;
            end
            default: begin
              if (!fetch_q) begin
                fetch_d  = 1'b1;
                oaddr_d  = FetchEnAddr;
                owdata_d = 32'h1;
                owe_d    = 1'b1;
                state_d  = EXEC_FETCH;
              end else begin
                state_d = STATUS;
              end
            end
          endcase
        end
      end
      RDTX: begin
        if (tx_fire) begin
          buf_d = {8'h00, buf_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (words_q != '0) begin
              oaddr_d  = addr_q;
              owdata_d = '0;
              owe_d    = 1'b0;
              state_d  = REQ;
            end else begin
              state_d = STATUS;
            end
          end
        end
      end
      STATUS: begin
        if (tx_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_RD;
      cnt_q    <= '0;
      addr_q   <= '0;
      words_q  <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
      fetch_q  <= 1'b0;
      tmo_q    <= '0;
      oaddr_q  <= '0;
      owdata_q <= '0;
      owe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
      fetch_q  <= fetch_d;
      tmo_q    <= tmo_d;
      oaddr_q  <= oaddr_d;
      owdata_q <= owdata_d;
      owe_q    <= owe_d;
    end
  end

endmodule

// File: tb/tb_uart_dbg_responder.sv
// Scoreboard bench for uart_dbg_responder: stimulus queues expected TX bytes
// and OBI requests; an OBI memory model and a TX monitor check them.
module tb_uart_dbg_responder;
  localparam int unsigned TMO = 64;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;
  logic        busy;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } obi_t;

  obi_t        exp_obi_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] mem [logic [31:0]];

  int          n_checks = 0;
  int          n_fail = 0;
  int          tx_count = 0;
  int          stall_at = -1;
  bit          rand_dly = 0;
  bit          err_en = 0;
  logic [31:0] err_addr = '0;

  uart_dbg_responder #(
    .TimeoutCycles(TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .obi_req_o   (obi_req),
    .obi_gnt_i   (obi_gnt),
    .obi_addr_o  (obi_addr),
    .obi_we_o    (obi_we),
    .obi_be_o    (obi_be),
    .obi_wdata_o (obi_wdata),
    .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i (obi_rdata),
    .obi_err_i   (obi_err),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // OBI memory model with optional random grant/response latency
  initial begin : obi_slave
    int          d;
    logic [31:0] a0;
    obi_t        e;
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata  = '0;
    obi_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (obi_req) begin
        a0 = obi_addr;
        d  = rand_dly ? int'($urandom_range(0, 10)) : 0;
        repeat (d) @(negedge clk);
        if (d > 0) begin
          chk("obi_req_held", {31'd0, obi_req}, 32'd1);
          chk("obi_addr_stable", obi_addr, a0);
        end
        if (exp_obi_q.size() == 0) begin
          fail_now("obi_unexpected", obi_addr);
        end else begin
          e = exp_obi_q.pop_front();
          chk("obi_addr", obi_addr, e.addr);
          chk("obi_we", {31'd0, obi_we}, {31'd0, e.we});
          chk("obi_be", {28'd0, obi_be}, 32'hF);
          if (e.we) chk("obi_wdata", obi_wdata, e.wdata);
        end
        a0 = obi_addr;
        if (obi_we) mem[a0] = obi_wdata;
        obi_gnt = 1'b1;
        @(negedge clk);
        obi_gnt = 1'b0;
        d = rand_dly ? int'($urandom_range(0, 10)) : 0;
        repeat (d) @(negedge clk);
        obi_rvalid = 1'b1;
        obi_rdata  = mem.exists(a0) ? mem[a0] : 32'h0;
        obi_err    = err_en && (a0 == err_addr);
        @(negedge clk);
        obi_rvalid = 1'b0;
        obi_err    = 1'b0;
        obi_rdata  = '0;
      end
    end
  end

  // TX monitor: pops the scoreboard on each handshake, checks hold stability
  initial begin : tx_monitor
    bit         held;
    logic [7:0] hd;
    held = 0;
    hd   = '0;
    forever begin
      @(negedge clk);
      if (held) begin
        chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("tx_hold_data", {24'd0, tx_data}, {24'd0, hd});
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          fail_now("tx_unexpected", {24'd0, tx_data});
        end else begin
          chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
        end
        tx_count++;
        held = 0;
      end else if (tx_valid) begin
        held = 1;
        hd   = tx_data;
      end else begin
        held = 0;
      end
    end
  end

  // TX backpressure: 50-cycle stall once tx_count hits stall_at
  initial begin : tx_drv
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && tx_count == stall_at && tx_valid) begin
        tx_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        stall_at = -1;
      end
    end
  end

  initial begin : watchdog
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("rx_ready_timeout", {24'd0, b});
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a,
                          input logic [31:0] len, input bit has_len);
    send_byte(c);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (has_len) begin
      for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic we,
                         input logic [31:0] wd);
    obi_t e;
    e.addr  = a;
    e.we    = we;
    e.wdata = wd;
    exp_obi_q.push_back(e);
  endtask

  task automatic exp_bytes(input logic [7:0] b[$]);
    foreach (b[i]) exp_tx_q.push_back(b[i]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || exp_tx_q.size() != 0 || exp_obi_q.size() != 0)
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, n < 5000}, 32'd1);
    if (n >= 5000) begin
      exp_tx_q.delete();
      exp_obi_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_obi_req", {31'd0, obi_req}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_obi_addr", obi_addr, 32'd0);
    chk("rst_obi_wdata", obi_wdata, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // two-word write, then read back
    exp_bus(32'h1000_0000, 1'b1, 32'h1234_5678);
    exp_bus(32'h1000_0004, 1'b1, 32'hDEAD_BEEF);
    exp_bytes('{8'h06});
    send_cmd(8'h12, 32'h1000_0000, 32'd8, 1);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    wait_done("write2");

    exp_bus(32'h1000_0000, 1'b0, 32'h0);
    exp_bus(32'h1000_0004, 1'b0, 32'h0);
    exp_bytes('{8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06});
    send_cmd(8'h11, 32'h1000_0000, 32'd8, 1);
    wait_done("read2");

    // LEN=3 read and LEN=0 write: no bus access
    exp_bytes('{8'h06});
    send_cmd(8'h11, 32'h1000_0000, 32'd3, 1);
    wait_done("read_len3");
    exp_bytes('{8'h06});
    send_cmd(8'h12, 32'h1000_0000, 32'd0, 1);
    wait_done("write_len0");

    // unaligned address, LEN low bits ignored, address wraps
    exp_bus(32'hFFFF_FFFC, 1'b1, 32'hAABB_CCDD);
    exp_bus(32'h0000_0000, 1'b1, 32'h1122_3344);
    exp_bytes('{8'h06});
    send_cmd(8'h12, 32'hFFFF_FFFE, 32'h0000_000B, 1);
    send_word(32'hAABB_CCDD);
    send_word(32'h1122_3344);
    wait_done("write_wrap");
    exp_bus(32'hFFFF_FFFC, 1'b0, 32'h0);
    exp_bus(32'h0000_0000, 1'b0, 32'h0);
    exp_bytes('{8'hDD, 8'hCC, 8'hBB, 8'hAA,
                8'h44, 8'h33, 8'h22, 8'h11, 8'h06});
    send_cmd(8'h11, 32'hFFFF_FFFD, 32'd8, 1);
    wait_done("read_wrap");

    // exec
    exp_bus(32'h0300_0000, 1'b1, 32'h1000_0080);
    exp_bus(32'h0300_0004, 1'b1, 32'h0000_0001);
    exp_bytes('{8'h06});
    send_cmd(8'h13, 32'h1000_0080, 32'd0, 0);
    wait_done("exec");

    // bus error on second word: data still sent, NAK status
    err_en   = 1;
    err_addr = 32'h1000_0004;
    exp_bus(32'h1000_0000, 1'b0, 32'h0);
    exp_bus(32'h1000_0004, 1'b0, 32'h0);
    exp_bytes('{8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04});
    send_cmd(8'h11, 32'h1000_0000, 32'd8, 1);
    wait_done("read_err");
    err_en = 0;
    exp_bus(32'h1000_0000, 1'b0, 32'h0);
    exp_bytes('{8'h78, 8'h56, 8'h34, 8'h12, 8'h06});
    send_cmd(8'h11, 32'h1000_0000, 32'd4, 1);
    wait_done("read_after_err");

    // inter-byte timeout after two address bytes
    send_byte(8'h11);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TMO - 3) @(negedge clk);
    chk("tmo_busy_before", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    chk("tmo_rx_ready", {31'd0, rx_ready}, 32'd1);
    exp_bus(32'h1000_0004, 1'b0, 32'h0);
    exp_bytes('{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06});
    send_cmd(8'h11, 32'h1000_0004, 32'd4, 1);
    wait_done("read_after_tmo");

    // unknown command
    exp_bytes('{8'h04});
    send_byte(8'h55);
    wait_done("unknown");

    // TX backpressure in the middle of the first word
    stall_at = tx_count + 3;
    exp_bus(32'h1000_0000, 1'b0, 32'h0);
    exp_bus(32'h1000_0004, 1'b0, 32'h0);
    exp_bytes('{8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06});
    send_cmd(8'h11, 32'h1000_0000, 32'd8, 1);
    wait_done("read_stall");
    chk("stall_taken", stall_at, -1);

    // random grant/response latency
    rand_dly = 1;
    exp_bus(32'h2000_0000, 1'b1, 32'h0102_0304);
    exp_bus(32'h2000_0004, 1'b1, 32'hA5A5_5A5A);
    exp_bus(32'h2000_0008, 1'b1, 32'hCAFE_F00D);
    exp_bytes('{8'h06});
    send_cmd(8'h12, 32'h2000_0000, 32'd12, 1);
    send_word(32'h0102_0304);
    send_word(32'hA5A5_5A5A);
    send_word(32'hCAFE_F00D);
    wait_done("rand_write");
    exp_bus(32'h2000_0000, 1'b0, 32'h0);
    exp_bus(32'h2000_0004, 1'b0, 32'h0);
    exp_bus(32'h2000_0008, 1'b0, 32'h0);
    exp_bytes('{8'h04, 8'h03, 8'h02, 8'h01, 8'h5A, 8'h5A, 8'hA5,
                8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h06});
    send_cmd(8'h11, 32'h2000_0000, 32'd12, 1);
    wait_done("rand_read");
    exp_bus(32'h0300_0000, 1'b1, 32'h2000_0100);
    exp_bus(32'h0300_0004, 1'b1, 32'h0000_0001);
    exp_bytes('{8'h06});
    send_cmd(8'h13, 32'h2000_0100, 32'd0, 0);
    wait_done("rand_exec");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_dbg_responder.md
# uart_dbg_responder

Target side of the UART debug protocol: consumes a byte stream from the SoC UART receiver, decodes Read (0x11), Write (0x12) and Exec (0x13) commands, and executes them as 32-bit OBI manager accesses on the crossbar. It returns data and status bytes through the UART transmitter's byte stream. With this block, a host can load and start a program over UART without JTAG.

## Interface
- `BootAddrAddr`, default 32'h0300_0000: soc_ctrl boot address register, written by Exec.
- `FetchEnAddr`, default 32'h0300_0004: soc_ctrl fetch-enable register, written with 1 by Exec.
- `TimeoutCycles`, default 20000: idle cycles allowed between received bytes inside a command.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: received byte valid.
- `rx_ready_o` out 1: byte accepted when `rx_valid_i && rx_ready_o`.
- `tx_data_o` out 8: byte to transmit.
- `tx_valid_o` out 1: transmit byte valid.
- `tx_ready_i` in 1: transmitter accepts the byte.
- `obi_req_o` out 1, `obi_gnt_i` in 1: OBI request/grant.
- `obi_addr_o` out 32, `obi_we_o` out 1, `obi_be_o` out 4, `obi_wdata_o` out 32: OBI request payload.
- `obi_rvalid_i` in 1, `obi_rdata_i` in 32, `obi_err_i` in 1: OBI response.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Frame format (host→block):** all multi-byte fields are little-endian.
  - Read: 0x11, ADDR[4], LEN[4].
  - Write: 0x12, ADDR[4], LEN[4], then the data bytes.
  - Exec: 0x13, ADDR[4].
- **Address and length handling:**
  - ADDR[1:0] are forced to 0.
  - Word count N = LEN[31:2]; LEN[1:0] are ignored, and no data bytes are expected for them.
- **Response (block→host):**
  - Read returns 4N data bytes (each word LSB first), then a status byte.
  - Write and Exec return the status byte only.
  - Status byte: 0x06 (ACK) if no `obi_err_i` was seen during the command, otherwise 0x04 (EOT/NAK).
- **Unknown command byte:** consumed; the block replies 0x04 and returns to IDLE.
- **States:**
  - IDLE: wait for the command byte.
  - ADDR: collect 4 bytes.
  - LEN: collect 4 bytes (Read/Write only).
  - WCOLLECT: collect 4 bytes into the word.
  - REQ: drive request until granted.
  - RESP: wait for `obi_rvalid_i`.
  - RDTX: send 4 bytes.
  - EXEC_BOOT: write ADDR to `BootAddrAddr`.
  - EXEC_FETCH: write 32'h1 to `FetchEnAddr`.
  - STATUS: send the status byte, then go to IDLE.
- **Read flow:** LEN → (N=0 ? STATUS : REQ) → RESP → RDTX → (remaining ? REQ : STATUS).
- **Write flow:** LEN → (N=0 ? STATUS : WCOLLECT) → REQ → RESP → (remaining ? WCOLLECT : STATUS).
- **Exec flow:** ADDR → EXEC_BOOT (REQ/RESP) → EXEC_FETCH (REQ/RESP) → STATUS.
- **Bus accesses:**
  - Every access uses `obi_be_o` = 4'hF.
  - The address increments by 4 after each response and wraps modulo 2^32.
  - On an error read, the data bytes are still sent: `obi_rdata_i` is captured as-is, and the sticky error flag is set.
  - The error flag clears on entry to ADDR.
- **Inter-byte timeout:**
  - Applies in ADDR, LEN and WCOLLECT.
  - A counter counts cycles without an accepted byte. It resets to 0 on every accepted byte.
  - When it reaches `TimeoutCycles`, the FSM returns to IDLE silently: no response, no bus access for the partial word.

## Timing
- **Reset values:** `obi_req_o` 0, `tx_valid_o` 0, `busy_o` 0; all data and address outputs 0; `rx_ready_o` 1 (IDLE).
- **`rx_ready_o`:** high only in IDLE, ADDR, LEN and WCOLLECT. Each of these states accepts one byte per cycle.
- **OBI request and response:**
  - At most one outstanding transaction.
  - `obi_req_o` rises the cycle after the last required byte is accepted.
  - Payload is stable while `obi_req_o` is high; `obi_req_o` drops the cycle after `obi_gnt_i`.
  - `obi_rvalid_i` is sampled from the cycle after the grant onward.
- **TX byte stream:**
  - `tx_valid_o` is held with `tx_data_o` stable until `tx_ready_i`.
  - Back-to-back bytes are allowed, with the next byte valid the cycle after the handshake.
  - The first RDTX byte is valid the cycle after `obi_rvalid_i`.
- **Reset mid-command:** returns to IDLE immediately, drops `obi_req_o` and `tx_valid_o`, and discards partial state. The in-flight OBI response is ignored.

## Test plan
- **Write/read:** Write 12 00 00 00 10 08 00 00 00 + bytes 78 56 34 12 EF BE AD DE → words 0x12345678 @0x10000000 and 0xDEADBEEF @0x10000004, reply 06. Then Read of the same range returns 78 56 34 12 EF BE AD DE 06.
- **Zero-length and unaligned length:**
  - Read with LEN=3 → no OBI request, reply 06.
  - Write LEN=0 → reply 06.
- **Exec:** 13 80 00 00 10 → write 0x10000080 to 0x03000000, then 0x1 to 0x03000004, reply 06.
- **Bus error:** `obi_err_i`=1 on the second word of a 2-word read → 8 data bytes sent, status 04. The next command returns 06.
- **Timeout and unknown command:**
  - Stall after 2 ADDR bytes for `TimeoutCycles` cycles → no reply, `busy_o` falls, and a following valid Read succeeds.
  - Command byte 0x55 → reply 04.
- **Backpressure and randomized stalls:** `tx_ready_i` low for 50 cycles mid-RDTX → `tx_data_o` stable, no lost bytes. Random `obi_gnt_i` and `obi_rvalid_i` delays (0–10 cycles) → identical byte stream.
